// File: rtl/qarctan_arbiter_pkg.sv
// qarctan_arbiter_pkg: shared state type and constants for the qarctan arbiter.
package qarctan_arbiter_pkg;
    typedef enum logic [1:0] {ARB, ISSUE, BUSY, RESPOND} qarb_state_t;
    localparam int QARB_MAX_REQ = 4;
    localparam int TIMEOUT_CYCLES = 2048;
    localparam int WDOG_W = 12;
    localparam int IDX_W = $clog2(QARB_MAX_REQ);
endpackage

// File: rtl/qarctan_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the first request at or after i_ptr wins.
module rr_pick
    import qarctan_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [N-1:0] w_rot;
    // Rotate so bit 0 is the requester at i_ptr; lowest set bit is the winner.
    assign w_rot = N'({i_req, i_req} >> i_ptr);
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) o_idx = IDX_W'((int'(i_ptr) + k) % N);
        o_any = |i_req;
        o_grant = o_any ? N'(1) << o_idx : '0;
    end
endmodule

// File: rtl/qarctan_arbiter.sv
// qarctan_arbiter: round-robin sharing of one qarctan between NUM_REQ requesters.
// Define QARCTAN_ARB_TIMEOUT_EN to add a BUSY watchdog that reports resp_err.
module qarctan_arbiter
    import qarctan_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_x,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_y,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_resp_valid,
    output logic [DATA_W-1:0]         o_resp_data,
    output logic                      o_resp_err,
    input  logic [NUM_REQ-1:0]        i_resp_ready,
    output logic                      o_q_start,
    output logic [DATA_W-1:0]         o_q_x,
    output logic [DATA_W-1:0]         o_q_y,
    input  logic                      i_q_ready,
    input  logic [DATA_W-1:0]         i_q_data,
    input  logic                      i_q_done
);
    qarb_state_t r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_owner, w_idx;
    logic [NUM_REQ-1:0] w_grant, w_owner_oh;
    logic w_any, w_accept, w_launch, w_done, w_timeout, w_release;
    logic [DATA_W-1:0] r_op_x, r_op_y, r_res, w_sel_x, w_sel_y;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel_x |= w_grant[k] ? i_req_x[k*DATA_W +: DATA_W] : '0;
            w_sel_y |= w_grant[k] ? i_req_y[k*DATA_W +: DATA_W] : '0;
        end
    end

    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_state_nxt = r_state;
        w_accept = 1'b0;
        w_launch = 1'b0;
        w_done = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ARB: begin
                w_accept = w_any;
                w_state_nxt = w_any ? ISSUE : ARB;
            end
            ISSUE: begin
                w_launch = i_q_ready;
                w_state_nxt = i_q_ready ? BUSY : ISSUE;
            end
            BUSY: begin
                w_done = i_q_done | w_timeout;
                w_state_nxt = w_done ? RESPOND : BUSY;
            end
            RESPOND: begin
                w_release = |(i_resp_ready & w_owner_oh);
                w_state_nxt = w_release ? ARB : RESPOND;
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign o_req_ready = (i_reset && r_state == ARB) ? w_grant : '0;
    assign o_resp_valid = (i_reset && r_state == RESPOND) ? w_owner_oh : '0;
    assign o_q_start = i_reset & w_launch;
    assign o_resp_data = r_res;
    assign o_q_x = r_op_x;
    assign o_q_y = r_op_y;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ARB;
            r_rr_ptr <= '0;
            r_owner <= '0;
            r_op_x <= '0;
            r_op_y <= '0;
            r_res <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_idx;
                r_op_x <= w_sel_x;
                r_op_y <= w_sel_y;
            end
            if (w_done) r_res <= i_q_done ? i_q_data : '0;
            if (w_release) r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

`ifdef QARCTAN_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog;
    logic r_err;
    // Loaded with 1 at launch so it equals cycles since q_start; RESPOND lands TIMEOUT_CYCLES after launch.
    assign w_timeout = (r_state == BUSY) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign o_resp_err = r_err;
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wdog <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_launch) r_wdog <= WDOG_W'(1);
            else if (r_state == BUSY) r_wdog <= r_wdog + 1'b1;
            if (w_done) r_err <= !i_q_done;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_resp_err = 1'b0;
`endif
endmodule
